ex_mem_stage: RTL
=================

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 ex_valid_i  input  1  EX holds an instruction this cycle.
REQ-004 ex_ready_o  output  1  stage accepts the EX instruction this cycle.
REQ-005 ex_pc_i  input  32  PC of the EX instruction.
REQ-006 ex_alu_i  input  32  ALU result; this is also the JALR target.
REQ-007 ex_br_mark_i  input  1  ALU branch condition; 1 for jumps.
REQ-008 ex_is_br_i  input  1  conditional branch.
REQ-009 ex_is_jump_i  input  1  JAL or JALR.
REQ-010 ex_target_i  input  32  precomputed branch/JAL target (pc+imm).
REQ-011 ex_is_jalr_i  input  1  use ex_alu_i with bit0 cleared as the target.
REQ-012 ex_rd_i  input  5  destination register.
REQ-013 ex_we_i  input  1  register write enable.
REQ-014 ex_memrd_i  input  1  load.
REQ-015 ex_memwr_i  input  1  store.
REQ-016 ex_sdata_i  input  32  store data.
REQ-017 mem_valid_o  output  1  MEM register holds a valid instruction.
REQ-018 mem_ready_i  input  1  MEM consumes the held instruction.
REQ-019 mem_result_o  output  32  ex_pc_i+4 for jumps, else ex_alu_i.
REQ-020 mem_rd_o  output  5  registered rd.
REQ-021 mem_we_o, mem_memrd_o, mem_memwr_o  output  1 each  registered controls.
REQ-022 mem_sdata_o  output  32  registered store data.
REQ-023 redirect_o  output  1  one-cycle pulse when a taken branch or jump is accepted.
REQ-024 redirect_pc_o  output  32  fetch target; valid while redirect_o=1.
REQ-025 flush_o  output  1  equals redirect_o; kills IF and ID.

Function
REQ-026 ex_ready_o SHALL be 1 when mem_valid_o=0 or mem_ready_i=1, and 0 otherwise.
REQ-027 An instruction is accepted when ex_valid_i=1, ex_ready_o=1 and state is RUN; accepted fields SHALL appear on the mem_* outputs the next cycle.
REQ-028 If nothing is accepted and mem_ready_i=1, mem_valid_o SHALL clear next cycle; if mem_ready_i=0, all mem_* outputs SHALL hold.
REQ-029 An accepted instruction is taken when (ex_is_br_i or ex_is_jump_i) and ex_br_mark_i=1.
REQ-030 A taken instruction SHALL drive redirect_o=1 for exactly one cycle, registered, in the cycle it appears on mem_valid_o.
REQ-031 redirect_pc_o SHALL be {ex_alu_i[31:1],1'b0} when ex_is_jalr_i=1, and ex_target_i otherwise.
REQ-032 mem_result_o SHALL use 32-bit modulo addition; pc 0xFFFFFFFC+4 wraps to 0.
REQ-033 FSM has two states, RUN and SQUASH. A taken accept SHALL move RUN to SQUASH and load squash_cnt=2.
REQ-034 In SQUASH, ex_ready_o SHALL be 1 and every ex_valid_i=1 SHALL be dropped (never reaches MEM) and SHALL decrement squash_cnt; at 0 the FSM SHALL return to RUN.
REQ-035 In SQUASH with ex_valid_i=0, squash_cnt SHALL hold; MEM drain per REQ-028 SHALL continue.
REQ-036 A not-taken branch SHALL pass through as a normal instruction with redirect_o=0.
REQ-037 A taken accept while mem_ready_i=0 cannot occur, because ex_ready_o=0 per REQ-026.

Reset
REQ-038 When rst is asserted, mem_valid_o, redirect_o and flush_o SHALL be 0, all data outputs 0, state RUN and squash_cnt 0, with immediate (asynchronous) effect.
REQ-039 Reset asserted mid-SQUASH SHALL discard the squash; the first post-reset accept SHALL proceed normally.

Configuration
REQ-040 With BRANCH_STATS_EN defined, the block SHALL add 32-bit outputs br_total_o (accepted branches and jumps) and br_taken_o (taken ones). Both reset to 0, wrap at 2^32, and do not count squashed instructions.
REQ-041 Without BRANCH_STATS_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-042 Reset: assert rst mid-stream -> all outputs 0 within the same cycle; state RUN.
REQ-043 Pass-through: ADD with alu=0x10, rd=5, we=1, mem_ready_i=1 -> next cycle mem_valid_o=1, mem_result_o=0x10, mem_rd_o=5, redirect_o=0.
REQ-044 Backpressure: mem_ready_i=0 for 3 cycles with EX valid -> ex_ready_o=0 and outputs hold; release -> next instruction appears one cycle later.
REQ-045 Taken branch: pc=0x100, target=0x80, br_mark=1 -> redirect_o=1 for one cycle with redirect_pc_o=0x80; the next two EX-valid instructions are dropped; the third reaches MEM.
REQ-046 JALR: pc=0x200, alu=0x305 -> redirect_pc_o=0x304 and mem_result_o=0x204; the same instruction with pc=0xFFFFFFFC -> mem_result_o=0.
REQ-047 Stats (BRANCH_STATS_EN): 3 branches (2 taken) plus 1 squashed branch -> br_total_o=3, br_taken_o=2.

Source files
------------

// File: rtl/ex_mem_stage_if.sv
// rtl/ex_mem_stage_if.sv - EX-to-MEM stage bus; BRANCH_STATS_EN adds branch counter outputs.
interface ex_mem_stage_if;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic [31:0] ex_pc_i;
  logic [31:0] ex_alu_i;
  logic        ex_br_mark_i;
  logic        ex_is_br_i;
  logic        ex_is_jump_i;
  logic [31:0] ex_target_i;
  logic        ex_is_jalr_i;
  logic [4:0]  ex_rd_i;
  logic        ex_we_i;
  logic        ex_memrd_i;
  logic        ex_memwr_i;
  logic [31:0] ex_sdata_i;
  logic        mem_valid_o;
  logic        mem_ready_i;
  logic [31:0] mem_result_o;
  logic [4:0]  mem_rd_o;
  logic        mem_we_o;
  logic        mem_memrd_o;
  logic        mem_memwr_o;
  logic [31:0] mem_sdata_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        flush_o;
`ifdef BRANCH_STATS_EN
  logic [31:0] br_total_o;
  logic [31:0] br_taken_o;
`endif

  modport slave (
    input  ex_valid_i, ex_pc_i, ex_alu_i, ex_br_mark_i, ex_is_br_i, ex_is_jump_i,
           ex_target_i, ex_is_jalr_i, ex_rd_i, ex_we_i, ex_memrd_i, ex_memwr_i,
           ex_sdata_i, mem_ready_i,
    output ex_ready_o, mem_valid_o, mem_result_o, mem_rd_o, mem_we_o, mem_memrd_o,
           mem_memwr_o, mem_sdata_o, redirect_o, redirect_pc_o, flush_o
`ifdef BRANCH_STATS_EN
   ,output br_total_o, br_taken_o
`endif
  );

  modport master (
    output ex_valid_i, ex_pc_i, ex_alu_i, ex_br_mark_i, ex_is_br_i, ex_is_jump_i,
           ex_target_i, ex_is_jalr_i, ex_rd_i, ex_we_i, ex_memrd_i, ex_memwr_i,
           ex_sdata_i, mem_ready_i,
    input  ex_ready_o, mem_valid_o, mem_result_o, mem_rd_o, mem_we_o, mem_memrd_o,
           mem_memwr_o, mem_sdata_o, redirect_o, redirect_pc_o, flush_o
`ifdef BRANCH_STATS_EN
   ,input  br_total_o, br_taken_o
`endif
  );
endinterface

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM pipeline register with branch redirect and 2-slot squash.
// Optional BRANCH_STATS_EN adds accepted/taken branch counters.
module ex_mem_stage (
  input  logic           clk,
  input  logic           rst,
  ex_mem_stage_if.slave  bus
);
  typedef enum logic {RUN, SQUASH} state_t;

  state_t      state_q, state_d;
  logic [1:0]  squash_cnt_q, squash_cnt_d;
  logic        mem_valid_q, mem_valid_d;
  logic [31:0] mem_result_q, mem_result_d;
  logic [4:0]  mem_rd_q, mem_rd_d;
  logic        mem_we_q, mem_we_d;
  logic        mem_memrd_q, mem_memrd_d;
  logic        mem_memwr_q, mem_memwr_d;
  logic [31:0] mem_sdata_q, mem_sdata_d;
  logic        redirect_q, redirect_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic ex_ready, accept, is_ctrl, taken;

  // Squash slots are dropped without touching MEM, so they never wait on backpressure.
  assign ex_ready = (state_q == SQUASH) || !mem_valid_q || bus.mem_ready_i;
  assign accept   = bus.ex_valid_i && ex_ready && (state_q == RUN);
  assign is_ctrl  = bus.ex_is_br_i || bus.ex_is_jump_i;
  assign taken    = accept && is_ctrl && bus.ex_br_mark_i;

  always_comb begin
    state_d      = state_q;
    squash_cnt_d = squash_cnt_q;
    case (state_q)
      RUN: begin
        if (taken) begin
          state_d      = SQUASH;
          squash_cnt_d = 2'd2;
        end
      end
      SQUASH: begin
        if (bus.ex_valid_i) begin
          squash_cnt_d = squash_cnt_q - 2'd1;
          if (squash_cnt_q == 2'd1) state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    mem_valid_d   = mem_valid_q;
    mem_result_d  = mem_result_q;
    mem_rd_d      = mem_rd_q;
    mem_we_d      = mem_we_q;
    mem_memrd_d   = mem_memrd_q;
    mem_memwr_d   = mem_memwr_q;
    mem_sdata_d   = mem_sdata_q;
    redirect_d    = taken;
    redirect_pc_d = redirect_pc_q;
    if (accept) begin
      mem_valid_d  = 1'b1;
      mem_result_d = bus.ex_is_jump_i ? bus.ex_pc_i + 32'd4 : bus.ex_alu_i;
      mem_rd_d     = bus.ex_rd_i;
      mem_we_d     = bus.ex_we_i;
      mem_memrd_d  = bus.ex_memrd_i;
      mem_memwr_d  = bus.ex_memwr_i;
      mem_sdata_d  = bus.ex_sdata_i;
    end else if (bus.mem_ready_i) begin
      mem_valid_d = 1'b0;
    end
    if (taken) begin
      redirect_pc_d = bus.ex_is_jalr_i ? {bus.ex_alu_i[31:1], 1'b0} : bus.ex_target_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      squash_cnt_q  <= 2'd0;
      mem_valid_q   <= 1'b0;
      mem_result_q  <= 32'd0;
      mem_rd_q      <= 5'd0;
      mem_we_q      <= 1'b0;
      mem_memrd_q   <= 1'b0;
      mem_memwr_q   <= 1'b0;
      mem_sdata_q   <= 32'd0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      squash_cnt_q  <= squash_cnt_d;
      mem_valid_q   <= mem_valid_d;
      mem_result_q  <= mem_result_d;
      mem_rd_q      <= mem_rd_d;
      mem_we_q      <= mem_we_d;
      mem_memrd_q   <= mem_memrd_d;
      mem_memwr_q   <= mem_memwr_d;
      mem_sdata_q   <= mem_sdata_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign bus.ex_ready_o    = ex_ready;
  assign bus.mem_valid_o   = mem_valid_q;
  assign bus.mem_result_o  = mem_result_q;
  assign bus.mem_rd_o      = mem_rd_q;
  assign bus.mem_we_o      = mem_we_q;
  assign bus.mem_memrd_o   = mem_memrd_q;
  assign bus.mem_memwr_o   = mem_memwr_q;
  assign bus.mem_sdata_o   = mem_sdata_q;
  assign bus.redirect_o    = redirect_q;
  assign bus.redirect_pc_o = redirect_pc_q;
  assign bus.flush_o       = redirect_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] br_total_q, br_total_d;
  logic [31:0] br_taken_q, br_taken_d;

  always_comb begin
    br_total_d = br_total_q;
    br_taken_d = br_taken_q;
    if (accept && is_ctrl) br_total_d = br_total_q + 32'd1;
    if (taken)             br_taken_d = br_taken_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_total_q <= 32'd0;
      br_taken_q <= 32'd0;
    end else begin
      br_total_q <= br_total_d;
      br_taken_q <= br_taken_d;
    end
  end

  assign bus.br_total_o = br_total_q;
  assign bus.br_taken_o = br_taken_q;
`endif
endmodule
